// File: rtl/pam_tx.sv
// PAM symbol transmitter: alternating preamble, then valid/ready symbols mapped to
// signed PAM levels and held for SPS samples. Define PAM_TX_GRAY_EN for Gray-coded in_data.
module pam_tx #(
  parameter int OWIDTH       = 14,
  parameter int BITS_PER_SYM = 2,
  parameter int SPS          = 8,
  parameter int LEVEL_STEP   = 2048,
  parameter int PREAMBLE_LEN = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BITS_PER_SYM-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OWIDTH-1:0]       out,
  output logic                    out_valid,
  output logic                    sym_strobe,
  output logic                    busy
);

  localparam int M  = 2 ** BITS_PER_SYM;
  localparam int PW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int CW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam logic [PW-1:0]            PH_LAST  = PW'(SPS - 1);
  localparam logic [CW-1:0]            CNT_LAST = CW'(PREAMBLE_LEN - 1);
  localparam logic signed [OWIDTH-1:0] PEAK     = OWIDTH'((M - 1) * LEVEL_STEP);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

  state_t            state, state_nx;
  logic [PW-1:0]     phase, phase_nx;
  logic [CW-1:0]     symcnt, symcnt_nx;
  logic [OWIDTH-1:0] out_nx;
  logic              strobe_nx;
  logic              active_nx;

  function automatic logic [OWIDTH-1:0] level(input logic [BITS_PER_SYM-1:0] sym);
    logic [BITS_PER_SYM-1:0] idx;
`ifdef PAM_TX_GRAY_EN
    for (int unsigned i = 0; i < BITS_PER_SYM; i++) idx[i] = ^(sym >> i);
`else
    idx = sym;
`endif
    return OWIDTH'((2 * int'(idx) - (M - 1)) * LEVEL_STEP);
  endfunction

  // phase/symcnt describe the sample currently on out, so a handshake at the
  // last phase loads the next symbol's first sample directly.
  always_comb begin
    in_ready  = (phase == PH_LAST) &&
                ((state == DATA) || ((state == PREAMBLE) && (symcnt == CNT_LAST)));
    state_nx  = state;
    phase_nx  = phase;
    symcnt_nx = symcnt;
    out_nx    = out;
    strobe_nx = 1'b0;
    case (state)
      IDLE: begin
        phase_nx  = '0;
        symcnt_nx = '0;
        out_nx    = '0;
        if (start) begin
          state_nx  = PREAMBLE;
          out_nx    = PEAK;
          strobe_nx = 1'b1;
        end
      end
      PREAMBLE, DATA: begin
        if (phase != PH_LAST) begin
          phase_nx = phase + 1'b1;
        end else if (in_ready) begin
          phase_nx = '0;
          if (in_valid) begin
            state_nx  = DATA;
            out_nx    = level(in_data);
            strobe_nx = 1'b1;
          end else begin
            state_nx  = IDLE;
            symcnt_nx = '0;
            out_nx    = '0;
          end
        end else begin
          phase_nx  = '0;
          symcnt_nx = symcnt + 1'b1;
          out_nx    = symcnt[0] ? PEAK : -PEAK;
          strobe_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    active_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      symcnt     <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      sym_strobe <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      phase      <= phase_nx;
      symcnt     <= symcnt_nx;
      out        <= out_nx;
      out_valid  <= active_nx;
      sym_strobe <= strobe_nx;
      busy       <= active_nx;
    end
  end

endmodule

// File: tb/tb_pam_tx.sv
// Directed bench for pam_tx: one instance with SPS=8/PREAMBLE_LEN=4, one with SPS=1/PREAMBLE_LEN=2.
module tb_pam_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, in_ready, out_valid, sym_strobe, busy;
  logic [1:0]  in_data;
  logic [13:0] out;
  logic        rst1, start1, in_valid1, in_ready1, out_valid1, sym_strobe1, busy1;
  logic [1:0]  in_data1;
  logic [13:0] out1;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic signed [13:0] PK = 14'sd6144;
  logic signed [13:0] lv [4];
  logic [1:0]         syms [8];

  pam_tx #(.OWIDTH(14), .BITS_PER_SYM(2), .SPS(8), .LEVEL_STEP(2048), .PREAMBLE_LEN(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .sym_strobe(sym_strobe), .busy(busy)
  );

  pam_tx #(.OWIDTH(14), .BITS_PER_SYM(2), .SPS(1), .LEVEL_STEP(2048), .PREAMBLE_LEN(2)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out(out1), .out_valid(out_valid1), .sym_strobe(sym_strobe1), .busy(busy1)
  );

  task automatic start_frame();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 2'b00;
    rst1 = 1'b1; start1 = 1'b0; in_valid1 = 1'b0; in_data1 = 2'b00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out1, out_valid1, busy1, sym_strobe1, in_ready1} !== 18'd0) begin
      n_err++;
      $display("FAIL reset1: got out=%0d v=%b b=%b s=%b r=%b, want all 0",
               $signed(out1), out_valid1, busy1, sym_strobe1, in_ready1);
    end
    rst = 1'b0; rst1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({out, out_valid, busy, sym_strobe, in_ready} !== 18'd0) begin
        n_err++;
        $display("FAIL idle[%0d]: got out=%0d v=%b b=%b s=%b r=%b, want all 0",
                 i, $signed(out), out_valid, busy, sym_strobe, in_ready);
      end
    end
  endtask

  task automatic test_preamble();
    logic signed [13:0] e;
    start_frame();
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      e = (((i / 8) % 2) == 0) ? PK : -PK;
      n_cmp++;
      if ({out, out_valid, busy, sym_strobe, in_ready} !==
          {e, 1'b1, 1'b1, (i % 8) == 0, i == 31}) begin
        n_err++;
        $display("FAIL pre[%0d]: got out=%0d v=%b b=%b s=%b r=%b, want out=%0d v=1 b=1 s=%b r=%b",
                 i, $signed(out), out_valid, busy, sym_strobe, in_ready, e, (i % 8) == 0, i == 31);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({out, out_valid, busy, sym_strobe, in_ready} !== 18'd0) begin
      n_err++;
      $display("FAIL pre_only_end: got out=%0d v=%b b=%b s=%b r=%b, want all 0",
               $signed(out), out_valid, busy, sym_strobe, in_ready);
    end
  endtask

  task automatic test_data();
    start_frame();
    in_valid = 1'b1; in_data = 2'b11;  // not ready during preamble: must be ignored
    repeat (31) @(negedge clk);
    n_cmp++;
    if ({out, in_ready} !== {-PK, 1'b1}) begin
      n_err++;
      $display("FAIL data_pre31: got out=%0d r=%b, want out=%0d r=1", $signed(out), in_ready, -PK);
    end
    in_data = 2'b00;
    for (int s = 0; s < 4; s++) begin
      for (int p = 0; p < 8; p++) begin
        @(negedge clk);
        n_cmp++;
        if ({out, out_valid, busy, sym_strobe, in_ready} !==
            {lv[s], 1'b1, 1'b1, p == 0, p == 7}) begin
          n_err++;
          $display("FAIL data[%0d.%0d]: got out=%0d v=%b b=%b s=%b r=%b, want out=%0d s=%b r=%b",
                   s, p, $signed(out), out_valid, busy, sym_strobe, in_ready, lv[s], p == 0, p == 7);
        end
        if (p == 3) in_data = ~in_data;
        if (p == 7) begin
          if (s < 3) in_data = 2'(s + 1);
          else in_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({out, out_valid, busy, sym_strobe, in_ready} !== 18'd0) begin
      n_err++;
      $display("FAIL data_end: got out=%0d v=%b b=%b s=%b r=%b, want all 0",
               $signed(out), out_valid, busy, sym_strobe, in_ready);
    end
  endtask

  task automatic test_gray();
    logic signed [13:0] e0, e1;
`ifdef PAM_TX_GRAY_EN
    e0 = 14'sd6144; e1 = 14'sd2048;
`else
    e0 = 14'sd2048; e1 = 14'sd6144;
`endif
    start_frame();
    repeat (31) @(negedge clk);
    in_valid = 1'b1; in_data = 2'b10;
    @(negedge clk);
    n_cmp++;
    if ({out, sym_strobe} !== {e0, 1'b1}) begin
      n_err++;
      $display("FAIL map_10: got out=%0d s=%b, want out=%0d s=1", $signed(out), sym_strobe, e0);
    end
    repeat (7) @(negedge clk);
    in_data = 2'b11;
    @(negedge clk);
    n_cmp++;
    if ({out, sym_strobe} !== {e1, 1'b1}) begin
      n_err++;
      $display("FAIL map_11: got out=%0d s=%b, want out=%0d s=1", $signed(out), sym_strobe, e1);
    end
    repeat (7) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out, out_valid, busy} !== 16'd0) begin
      n_err++;
      $display("FAIL map_end: got out=%0d v=%b b=%b, want all 0", $signed(out), out_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    start_frame();
    repeat (31) @(negedge clk);
    in_valid = 1'b1; in_data = 2'b01;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out, sym_strobe} !== {lv[1], 1'b0}) begin
      n_err++;
      $display("FAIL mid_sym: got out=%0d s=%b, want out=%0d s=0", $signed(out), sym_strobe, lv[1]);
    end
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out, out_valid, busy, sym_strobe, in_ready} !== 18'd0) begin
      n_err++;
      $display("FAIL mid_rst: got out=%0d v=%b b=%b s=%b r=%b, want all 0",
               $signed(out), out_valid, busy, sym_strobe, in_ready);
    end
    rst = 1'b0;
    start_frame();
    n_cmp++;
    if ({out, out_valid, busy, sym_strobe, in_ready} !== {PK, 4'b1110}) begin
      n_err++;
      $display("FAIL restart: got out=%0d v=%b b=%b s=%b r=%b, want out=%0d v=1 b=1 s=1 r=0",
               $signed(out), out_valid, busy, sym_strobe, in_ready, PK);
    end
    repeat (32) @(negedge clk);
    n_cmp++;
    if ({out, busy} !== 15'd0) begin
      n_err++;
      $display("FAIL restart_end: got out=%0d b=%b, want 0", $signed(out), busy);
    end
  endtask

  task automatic test_back_to_back();
    start_frame();
    start = 1'b1;  // start is ignored outside IDLE
    repeat (31) @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({out, in_ready, busy} !== {-PK, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_last: got out=%0d r=%b b=%b, want out=%0d r=1 b=1",
               $signed(out), in_ready, busy, -PK);
    end
    @(negedge clk);
    n_cmp++;
    if ({out, out_valid, busy} !== 16'd0) begin
      n_err++;
      $display("FAIL b2b_gap: got out=%0d v=%b b=%b, want all 0", $signed(out), out_valid, busy);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({out, out_valid, busy, sym_strobe} !== {PK, 3'b111}) begin
      n_err++;
      $display("FAIL b2b_restart: got out=%0d v=%b b=%b s=%b, want out=%0d v=1 b=1 s=1",
               $signed(out), out_valid, busy, sym_strobe, PK);
    end
    repeat (32) @(negedge clk);
    n_cmp++;
    if ({out, busy} !== 15'd0) begin
      n_err++;
      $display("FAIL b2b_end: got out=%0d b=%b, want 0", $signed(out), busy);
    end
  endtask

  task automatic test_sps1();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    n_cmp++;
    if ({out1, out_valid1, busy1, sym_strobe1, in_ready1} !== {PK, 4'b1110}) begin
      n_err++;
      $display("FAIL s1_pre0: got out=%0d v=%b b=%b s=%b r=%b, want out=%0d v=1 b=1 s=1 r=0",
               $signed(out1), out_valid1, busy1, sym_strobe1, in_ready1, PK);
    end
    in_valid1 = 1'b1; in_data1 = 2'b11;
    @(negedge clk);
    n_cmp++;
    if ({out1, out_valid1, busy1, sym_strobe1, in_ready1} !== {-PK, 4'b1111}) begin
      n_err++;
      $display("FAIL s1_pre1: got out=%0d v=%b b=%b s=%b r=%b, want out=%0d v=1 b=1 s=1 r=1",
               $signed(out1), out_valid1, busy1, sym_strobe1, in_ready1, -PK);
    end
    in_data1 = syms[0];
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      n_cmp++;
      if ({out1, out_valid1, busy1, sym_strobe1, in_ready1} !== {lv[syms[j]], 4'b1111}) begin
        n_err++;
        $display("FAIL s1_data[%0d]: got out=%0d v=%b b=%b s=%b r=%b, want out=%0d v=1 b=1 s=1 r=1",
                 j, $signed(out1), out_valid1, busy1, sym_strobe1, in_ready1, lv[syms[j]]);
      end
      if (j < 7) in_data1 = syms[j + 1];
      else in_valid1 = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if ({out1, out_valid1, busy1, sym_strobe1, in_ready1} !== 18'd0) begin
      n_err++;
      $display("FAIL s1_end: got out=%0d v=%b b=%b s=%b r=%b, want all 0",
               $signed(out1), out_valid1, busy1, sym_strobe1, in_ready1);
    end
  endtask

  initial begin
`ifdef PAM_TX_GRAY_EN
    lv = '{-14'sd6144, -14'sd2048, 14'sd6144, 14'sd2048};
`else
    lv = '{-14'sd6144, -14'sd2048, 14'sd2048, 14'sd6144};
`endif
    syms = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    test_reset();
    test_preamble();
    test_data();
    test_gray();
    test_reset_mid();
    test_back_to_back();
    test_sps1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
